// File: rtl/pps_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : pps_reg_responder
// Description : clk_pps-side register responder. Pops {is_write, addr, data}
//               commands from the to_pps FIFO, applies writes to the timer
//               configuration registers and pushes one result word per read
//               into the from_pps FIFO. Reads of the low timestamp halves
//               snapshot the matching high halves into shadow registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pps_reg_responder #(
    parameter logic [31:0] ACCUM_INCR_RST = 32'h0000_0000,
    parameter logic [31:0] PPS_COUNT_RST  = 32'd120_000_000,
    parameter logic [31:0] TIME_INCR_VAL  = 32'd10
) (
    input  logic        clk_pps,
    input  logic        reset,
    input  logic [35:0] data_to_pps,
    input  logic        to_pps_empty,
    output logic        to_pps_rd_en,
    output logic [31:0] data_from_pps,
    input  logic        from_pps_full,
    output logic        from_pps_wr_en,
    input  logic [63:0] time_stamp,
    input  logic [63:0] event_stamp,
    output logic [31:0] accum_incr,
    output logic [31:0] pps_count,
    output logic [31:0] time_incr,
    output logic [2:0]  cfg_wr_stb
);

    localparam logic [2:0] c_ADDR_TIME_LO  = 3'd0;
    localparam logic [2:0] c_ADDR_TIME_HI  = 3'd1;
    localparam logic [2:0] c_ADDR_ACCUM    = 3'd2;
    localparam logic [2:0] c_ADDR_PPS_CNT  = 3'd3;
    localparam logic [2:0] c_ADDR_TIME_INC = 3'd4;
    localparam logic [2:0] c_ADDR_EVT_LO   = 3'd5;
    localparam logic [2:0] c_ADDR_EVT_HI   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POP       = 3'd1,
        S_DECODE    = 3'd2,
        S_PUSH      = 3'd3,
        S_PUSH_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_rd_en;
    logic        r_wr_en;
    logic [31:0] r_rd_data;
    logic [31:0] r_accum_incr;
    logic [31:0] r_pps_count;
    logic [31:0] r_time_incr;
    logic [2:0]  r_cfg_wr_stb;
    logic [31:0] r_time_hi_shadow;
    logic [31:0] r_event_hi_shadow;

    // Command word fields; only meaningful while in S_DECODE
    logic        w_is_write;
    logic [2:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] w_rd_val;

    assign w_is_write = data_to_pps[35];
    assign w_addr     = data_to_pps[34:32];
    assign w_data     = data_to_pps[31:0];

    // Read-data mux over the address map; unmapped address returns zero
    always_comb begin
        w_rd_val = 32'h0;
        case (w_addr)
            c_ADDR_TIME_LO:  w_rd_val = time_stamp[31:0];
            c_ADDR_TIME_HI:  w_rd_val = r_time_hi_shadow;
            c_ADDR_ACCUM:    w_rd_val = r_accum_incr;
            c_ADDR_PPS_CNT:  w_rd_val = r_pps_count;
            c_ADDR_TIME_INC: w_rd_val = r_time_incr;
            c_ADDR_EVT_LO:   w_rd_val = event_stamp[31:0];
            c_ADDR_EVT_HI:   w_rd_val = r_event_hi_shadow;
            default:         w_rd_val = 32'h0;
        endcase
    end

    // Command sequencer: pop, decode, apply write or produce and push a result
    always_ff @(posedge clk_pps) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_rd_en           <= 1'b0;
            r_wr_en           <= 1'b0;
            r_rd_data         <= 32'h0;
            r_accum_incr      <= ACCUM_INCR_RST;
            r_pps_count       <= PPS_COUNT_RST;
            r_time_incr       <= TIME_INCR_VAL;
            r_cfg_wr_stb      <= 3'b000;
            r_time_hi_shadow  <= 32'h0;
            r_event_hi_shadow <= 32'h0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed in S_DECODE
            r_cfg_wr_stb <= 3'b000;
            case (r_state)
                S_IDLE: begin
                    if (!to_pps_empty) begin
                        r_rd_en <= 1'b1;
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    // FIFO presents the popped word on its Q after this edge
                    r_rd_en <= 1'b0;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_is_write) begin
                        case (w_addr)
                            c_ADDR_ACCUM: begin
                                r_accum_incr <= w_data;
                                r_cfg_wr_stb <= 3'b001;
                            end
                            c_ADDR_PPS_CNT: begin
                                r_pps_count  <= w_data;
                                r_cfg_wr_stb <= 3'b010;
                            end
                            c_ADDR_TIME_INC: begin
                                r_time_incr  <= w_data;
                                r_cfg_wr_stb <= 3'b100;
                            end
                            default: begin
                                // Read-only or unmapped: write is dropped
                            end
                        endcase
                        r_state <= S_IDLE;
                    end else begin
                        r_rd_data <= w_rd_val;
                        // High half captured in the same cycle as the low half
                        if (w_addr == c_ADDR_TIME_LO) begin
                            r_time_hi_shadow <= time_stamp[63:32];
                        end
                        if (w_addr == c_ADDR_EVT_LO) begin
                            r_event_hi_shadow <= event_stamp[63:32];
                        end
                        r_state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    // Hold the result stable until the response FIFO has room
                    if (!from_pps_full) begin
                        r_wr_en <= 1'b1;
                        r_state <= S_PUSH_DONE;
                    end
                end
                S_PUSH_DONE: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign to_pps_rd_en   = r_rd_en;
    assign from_pps_wr_en = r_wr_en;
    assign data_from_pps  = r_rd_data;
    assign accum_incr     = r_accum_incr;
    assign pps_count      = r_pps_count;
    assign time_incr      = r_time_incr;
    assign cfg_wr_stb     = r_cfg_wr_stb;

endmodule
`default_nettype wire

// File: doc/pps_reg_responder.md
# pps_reg_responder

Register-access responder on the pps_timer side of the clock-domain-crossing FIFO pair. Pops command words `{is_write, addr[2:0], data[31:0]}` from the to_pps FIFO in the clk_pps domain and applies writes to the timer's configuration registers. For reads, it pushes one 32-bit result word into the from_pps FIFO. It is the far end of the core-side request/response path and supplies accum_incr, pps_count and time_incr to the timer datapath.

## Interface
Parameters:
- `ACCUM_INCR_RST`, 32'h0000_0000: reset value of accum_incr.
- `PPS_COUNT_RST`, 32'd120_000_000: reset value of pps_count.
- `TIME_INCR_VAL`, 'd10: reset value of time_incr.

Ports:
- `clk_pps` input 1: single clock for all logic.
- `reset` input 1: synchronous, active-high reset.
- `data_to_pps` input 36: FIFO Q. Bit 35 is is_write, [34:32] is addr, [31:0] is data.
- `to_pps_empty` input 1: to_pps FIFO empty.
- `to_pps_rd_en` output 1: to_pps FIFO read enable.
- `data_from_pps` output 32: read result to the from_pps FIFO.
- `from_pps_full` input 1: from_pps FIFO full.
- `from_pps_wr_en` output 1: from_pps FIFO write enable.
- `time_stamp` input 64: live timestamp from the timer.
- `event_stamp` input 64: latched event timestamp from the timer.
- `accum_incr` output 32: register 2.
- `pps_count` output 32: register 3.
- `time_incr` output 32: register 4.
- `cfg_wr_stb` output 3: one-cycle write strobes. Bit 0 is accum_incr, bit 1 is pps_count, bit 2 is time_incr.

## Operation
Address map:
- 0: time_stamp[31:0] (RO). Reading captures time_stamp[63:32] into time_hi_shadow in the same cycle.
- 1: time_hi_shadow (RO).
- 2 / 3 / 4: accum_incr / pps_count / time_incr (RW, readback of the current value).
- 5: event_stamp[31:0] (RO). Reading captures event_stamp[63:32] into event_hi_shadow.
- 6: event_hi_shadow (RO).
- 7: unmapped. Reads return 32'h0; writes are dropped.
- Writes to RO addresses (0, 1, 5, 6) are dropped: no register change, no strobe.

State machine (all control outputs registered):
- IDLE: if !to_pps_empty, set to_pps_rd_en<=1 and go to POP. Otherwise stay.
- POP: set to_pps_rd_en<=0. The FIFO advances Q this edge. Go to DECODE.
- DECODE: data_to_pps is valid.
  - Write: update the addressed register, pulse the matching cfg_wr_stb bit for one cycle, go to IDLE.
  - Read: load data_from_pps with the mapped value, update the shadow if addr is 0 or 5, go to PUSH.
- PUSH: if !from_pps_full, set from_pps_wr_en<=1 and go to PUSH_DONE. Otherwise hold in PUSH with data_from_pps stable.
- PUSH_DONE: set from_pps_wr_en<=0 and go to IDLE.

Rules:
- Exactly one result word is pushed per read command, in command order.
- No result word is pushed for a write command.
- Shadows change only on reads of address 0 or 5. Reading 1 or 6 with no prior low-half read returns the reset shadow value, 0.
- Register write takes full 32 bits; no byte enables.

## Timing
- Reset values:
  - to_pps_rd_en=0, from_pps_wr_en=0, cfg_wr_stb=0, data_from_pps=0.
  - Both shadows=0.
  - accum_incr=ACCUM_INCR_RST, pps_count=PPS_COUNT_RST, time_incr=TIME_INCR_VAL.
  - State=IDLE.
- to_pps_rd_en and from_pps_wr_en are each high for exactly one cycle per command.
- to_pps_rd_en is never high while to_pps_empty was high at the preceding edge.
- from_pps_wr_en is never high while from_pps_full was high at the preceding edge.
- Write latency: empty deasserted at cycle N gives rd_en high in N+1, register updated and strobe high in N+3, back to IDLE with the next pop possible at N+3.
- Read latency: result registered in N+3, wr_en high in N+4 if not full. Back-to-back reads take 5 cycles each.
- A full FIFO stalls in PUSH indefinitely. No further commands are popped while stalled.
- Reset asserted mid-command aborts it at the next edge. The popped command is lost, and any pending push is not performed.
- Snapshot coherence: the low and high halves of a shadowed read are sampled in the same DECODE cycle.

## Test plan
- Reset check: assert reset for 2 cycles, then read address 4 -> one push with data 32'd10; all strobes 0 during and after reset.
- Write/readback: write 32'h1234_5678 to address 2 -> accum_incr=32'h1234_5678 and cfg_wr_stb=3'b001 for one cycle. A following read of address 2 pushes 32'h1234_5678, and no push occurs for the write.
- Coherent snapshot: time_stamp=64'h0000_0001_FFFF_FFFF at DECODE of a read of address 0, then time_stamp advances to 64'h0000_0002_0000_0005. Read 0 pushes 32'hFFFF_FFFF; read 1 pushes 32'h0000_0001.
- Backpressure: hold from_pps_full=1 during a read of address 5. The block stays in PUSH, pushes event_stamp[31:0] only after full drops, and to_pps_rd_en stays 0 throughout.
- Illegal access: write 32'hDEAD_BEEF to address 0 and address 7 -> no register changes and cfg_wr_stb stays 0. A read of address 7 pushes 32'h0.
- Reset mid-read: assert reset in the PUSH cycle -> no wr_en pulse, all outputs at reset values on the next cycle, and the following command is processed normally.
